// File: rtl/display_scan.sv
// rtl/display_scan.sv - time-multiplexed 7-segment digit scanner
//
// Purpose:
//   Scans a bank of common-anode 7-segment digits one at a time. A packed
//   multi-digit hex value is staged on load and committed to the displayed
//   copy only when the scan wraps to digit 0, so a number never tears mid-scan.
//   Each digit slot starts with a guard interval with all digits off
//   (anti-ghosting). Optional leading-zero blanking is supported.
//
// Ports:
//   clk      - system clock, all state on the rising edge
//   rst_n    - asynchronous active-low reset
//   load     - strobe, captures value into the staging register
//   value    - packed digits, value[3:0] is digit 0 (rightmost)
//   blank_lz - enables leading-zero blanking
//   num      - nibble of the selected digit, to the segment decoder
//   an       - active-low digit enables, at most one bit low
//   frame    - one-cycle pulse after the scan wraps to digit 0
//   pending  - a staged value is waiting for commit

`timescale 1ns/1ps

module display_scan #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  blank_lz,
  output logic [3:0]            num,
  output logic [DIGITS-1:0]     an,
  output logic                  frame,
  output logic                  pending
);

  // GUARD < REFRESH_DIV, so the prescaler width also holds the guard count.
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [CW-1:0] GUARD_INIT = CW'(GUARD);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         gcnt_q, gcnt_d;
  logic [4*DIGITS-1:0]   staged_q, staged_d;
  logic [4*DIGITS-1:0]   shown_q, shown_d;
  logic                  pending_q, pending_d;
  logic [3:0]            num_q, num_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic                  frame_q, frame_d;

  logic                  tick;
  logic                  wrap;
  logic                  zero_above;
  logic [DIGITS-1:0]     blanked;

  always_comb begin
    tick = (cnt_q == CNT_LAST);
    wrap = tick && (idx_q == IDX_LAST);

    cnt_d = tick ? '0 : cnt_q + 1'b1;

    idx_d = idx_q;
    if (tick) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end

    gcnt_d = gcnt_q;
    if (tick) begin
      gcnt_d = GUARD_INIT;
    end else if (gcnt_q != '0) begin
      gcnt_d = gcnt_q - 1'b1;
    end

    // A load on the wrap tick bypasses staging and is shown immediately;
    // otherwise the wrap commits whatever was last staged.
    staged_d  = staged_q;
    shown_d   = shown_q;
    pending_d = pending_q;
    if (wrap) begin
      if (load) begin
        staged_d = value;
        shown_d  = value;
      end else if (pending_q) begin
        shown_d = staged_q;
      end
      pending_d = 1'b0;
    end else if (load) begin
      staged_d  = value;
      pending_d = 1'b1;
    end

    // Digit i is a leading zero when it and every digit above it are zero.
    zero_above = 1'b1;
    blanked    = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (shown_d[4*i +: 4] == 4'h0);
      blanked[i] = blank_lz & zero_above;
    end

    // Outputs are computed from next state so they change on the same edge
    // as the index and commit.
    num_d = '0;
    an_d  = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_d == IW'(i)) begin
        num_d = shown_d[4*i +: 4];
        if ((gcnt_d == '0) && !blanked[i]) begin
          an_d[i] = 1'b0;
        end
      end
    end

    frame_d = wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      gcnt_q    <= GUARD_INIT;
      staged_q  <= '0;
      shown_q   <= '0;
      pending_q <= 1'b0;
      num_q     <= '0;
      an_q      <= '1;
      frame_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      gcnt_q    <= gcnt_d;
      staged_q  <= staged_d;
      shown_q   <= shown_d;
      pending_q <= pending_d;
      num_q     <= num_d;
      an_q      <= an_d;
      frame_q   <= frame_d;
    end
  end

  assign num     = num_q;
  assign an      = an_q;
  assign frame   = frame_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_display_scan.sv
// tb/tb_display_scan.sv - scoreboard bench for display_scan

`timescale 1ns/1ps

module tb_display_scan;

  localparam int DIGITS      = 4;
  localparam int REFRESH_DIV = 4;
  localparam int GUARD       = 1;
  localparam int FRAME_LEN   = DIGITS * REFRESH_DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic        blank_lz;
  logic [3:0]  num;
  logic [3:0]  an;
  logic        frame;
  logic        pending;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] num;
    logic       frame;
    logic       pending;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  // Bench view of the scan: edges since reset release and the value state.
  int          k;
  logic [15:0] m_shown;
  logic [15:0] m_staged;
  logic        m_pend;

  display_scan #(
    .DIGITS      (DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .GUARD       (GUARD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .value    (value),
    .blank_lz (blank_lz),
    .num      (num),
    .an       (an),
    .frame    (frame),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv)
      else begin
        failures++;
        $error("FAIL %s at k=%0d observed=%h expected=%h", tag, k, obs, expv);
      end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_an"},      16'(an),      16'h000F);
    chk({tag, "_num"},     16'(num),     16'h0000);
    chk({tag, "_frame"},   16'(frame),   16'h0000);
    chk({tag, "_pending"}, 16'(pending), 16'h0000);
  endtask

  // One clock cycle: drive inputs, predict the post-edge outputs, push the
  // prediction, clock, then pop and compare against the DUT.
  task automatic cycle(input logic ld, input logic [15:0] val, input logic blz);
    exp_t        e;
    exp_t        got;
    int          kn, pos, dig;
    logic        wr;
    logic [15:0] upper;
    logic [3:0]  one_hot;
    load     = ld;
    value    = val;
    blank_lz = blz;
    kn  = k + 1;
    pos = kn % REFRESH_DIV;
    dig = (kn / REFRESH_DIV) % DIGITS;
    wr  = (pos == 0) && (dig == 0);
    if (wr) begin
      if (ld) begin
        m_shown  = val;
        m_staged = val;
      end else if (m_pend) begin
        m_shown = m_staged;
      end
      m_pend = 1'b0;
    end else if (ld) begin
      m_staged = val;
      m_pend   = 1'b1;
    end
    upper     = m_shown >> (4 * dig);
    one_hot   = 4'b0001 << dig;
    e.num     = upper[3:0];
    e.an      = ((pos < GUARD) || (blz && dig != 0 && upper == 16'h0)) ? 4'hF : ~one_hot;
    e.frame   = wr;
    e.pending = m_pend;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    load = 1'b0;
    k    = kn;
    got  = '{an: an, num: num, frame: frame, pending: pending};
    e    = exp_q.pop_front();
    chk("an",      16'(got.an),      16'(e.an));
    chk("num",     16'(got.num),     16'(e.num));
    chk("frame",   16'(got.frame),   16'(e.frame));
    chk("pending", 16'(got.pending), 16'(e.pending));
  endtask

  task automatic model_reset();
    k        = 0;
    m_shown  = '0;
    m_staged = '0;
    m_pend   = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    load     = 1'b0;
    value    = '0;
    blank_lz = 1'b0;
    model_reset();

    // Reset held across edges.
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("in_reset");
    rst_n = 1'b1;
    #1;
    chk_reset_state("released");

    // Idle scan: an 1111 then 1110, digit rotation, frame at 16.
    repeat (20) cycle(1'b0, 16'h0, 1'b0);

    // Mid-frame load, committed at next wrap.
    cycle(1'b1, 16'h1234, 1'b0);
    repeat (27) cycle(1'b0, 16'h0, 1'b0);

    // Two loads in one frame, last wins, with leading-zero blanking.
    cycle(1'b1, 16'hAAAA, 1'b1);
    repeat (3) cycle(1'b0, 16'h0, 1'b1);
    cycle(1'b1, 16'h00F0, 1'b1);
    repeat (30) cycle(1'b0, 16'h0, 1'b1);

    // Load exactly on the wrap tick.
    for (int i = 0; i < FRAME_LEN && ((k + 1) % FRAME_LEN) != 0; i++) cycle(1'b0, 16'h0, 1'b0);
    cycle(1'b1, 16'h5678, 1'b0);
    chk("wrap_load_num",     16'(num),     16'h0008);
    chk("wrap_load_pending", 16'(pending), 16'h0000);
    repeat (16) cycle(1'b0, 16'h0, 1'b0);

    // All zero: only digit 0 with blanking, all four without.
    cycle(1'b1, 16'h0000, 1'b1);
    repeat (33) cycle(1'b0, 16'h0, 1'b1);
    repeat (16) cycle(1'b0, 16'h0, 1'b0);

    // Reset mid-slot with a pending value.
    for (int i = 0; i < FRAME_LEN && ((k + 1) % FRAME_LEN) != 5; i++) cycle(1'b0, 16'h0, 1'b0);
    cycle(1'b1, 16'h9ABC, 1'b0);
    repeat (2) cycle(1'b0, 16'h0, 1'b0);
    chk("pre_reset_pending", 16'(pending), 16'h0001);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state("async_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    #1;
    chk_reset_state("re_released");
    repeat (20) cycle(1'b0, 16'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_scan.md
# display_scan

Time-multiplexed scanner for a bank of common-anode 7-segment digits. It holds a packed multi-digit hex value and presents one nibble at a time on `num`, which feeds the per-digit hex-to-segment decoder. It drives the matching active-low digit enable, with anti-ghosting guard time and optional leading-zero blanking. New values are staged and committed only at frame boundaries, so a displayed number never tears mid-scan.

## Interface
- `DIGITS`, 4: number of multiplexed digits (≥2).
- `REFRESH_DIV`, 50000: clock cycles each digit is selected (≥2).
- `GUARD`, 16: cycles at the start of each digit slot with all digits off (0 ≤ GUARD < REFRESH_DIV).

Ports:
- `clk` in 1: single system clock; all state on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `load` in 1: strobe; captures `value` into the staging register.
- `value` in 4*DIGITS: packed digits; `value[3:0]` is digit 0 (least significant, rightmost).
- `blank_lz` in 1: enables leading-zero blanking.
- `num` out 4: nibble of the currently selected digit, to the segment decoder.
- `an` out DIGITS: digit enables, active-low, at most one bit low.
- `frame` out 1: one-cycle pulse when the scan wraps to digit 0.
- `pending` out 1: staged value waiting for commit.

## Operation
- Registers:
  - prescaler `cnt` (0..REFRESH_DIV-1)
  - digit index `idx` (0..DIGITS-1)
  - guard counter `gcnt`
  - `staged`, `shown` (4*DIGITS each)
  - `pending`
- Tick: asserted when `cnt == REFRESH_DIV-1`. `cnt` wraps to 0, otherwise increments every cycle.
- On tick, `idx <= (idx == DIGITS-1) ? 0 : idx+1`, `gcnt <= GUARD`.
- Load: `load` high → `staged <= value`, `pending <= 1`. A repeated load before commit overwrites; only the last value is committed.
- Commit: on the tick that wraps `idx` to 0, if `pending`, then `shown <= staged`, `pending <= 0`.
- Load coinciding with the wrap tick: `shown <= value` (the new input) and `pending <= 0`. Load wins over the old staged value.
- `num` is registered: `num <= shown[4*idx_next +: 4]`. It updates on the same edge as `idx`, and also on commit.
- `an` is registered:
  - All ones while `gcnt != 0`; `gcnt` decrements each cycle to 0.
  - Otherwise only bit `idx` is low, unless that digit is blanked.
- Blanking: digit i (i ≥ 1) is blanked when `blank_lz` = 1 and nibbles i..DIGITS-1 of `shown` are all zero. Digit 0 is never blanked. A blanked slot keeps `an` all ones; `num` is still driven.
- `frame` is registered: high for exactly one cycle following the edge where `idx` becomes 0.

## Timing
- Reset (async assert, while `rst_n` = 0):
  - `cnt = 0`, `idx = 0`, `gcnt = GUARD`
  - `staged = shown = 0`, `pending = 0`
  - `num = 0`, `an` = all ones, `frame = 0`
- After reset release: `an` stays all ones for GUARD cycles, then `an[0]` goes low.
- Digit slot = REFRESH_DIV cycles: GUARD cycles off, REFRESH_DIV−GUARD cycles on. Frame period = DIGITS*REFRESH_DIV cycles.
- `num` changes on the tick edge; `an` goes all ones on that same edge when GUARD > 0. With GUARD = 0, `an` moves directly to the new digit on the tick edge.
- Load → `pending` high at the next edge. Commit latency is up to one frame. The new value is visible on `num` at digit 0 immediately after the wrap.
- Reset mid-scan or mid-pending discards the staged value; scanning restarts at digit 0.
- `blank_lz` is sampled combinationally into the registered `an`. A change takes effect on the next edge with `gcnt == 0`.

## Test plan
- Reset, DIGITS=4, REFRESH_DIV=4, GUARD=1 → `an=1111`, `num=0` during reset; after release, `an=1111` for 1 cycle, then `1110`. `an` sequence per slot: `1101`, `1011`, `0111`, `1110`, with `frame` pulsing every 16 cycles.
- Load `value=16'h1234` mid-frame → `pending=1`; `shown` unchanged until the wrap. After the wrap, `num` sequence `4,3,2,1` per slot and `pending=0`.
- Two loads in one frame (`16'hAAAA`, then `16'h00F0`) → only `00F0` is displayed. With `blank_lz=1`: digits 2 and 3 are blanked (`an=1111` in their slots); digit 0 shows `num=0` with `an=1110`.
- Load `16'h5678` on the exact wrap-tick cycle → `num=8` on that edge, `pending` stays 0.
- `value=16'h0000`, `blank_lz=1` → only digit 0 is lit, `num=0`. With `blank_lz=0`, all four digits light.
- Assert `rst_n=0` mid-slot with `pending=1` → outputs reset immediately, without waiting for a clock. After release, `shown=0`, `pending=0`, scan restarts at `an[0]` after GUARD cycles.
